leg_sequencer: RTL and testbench
================================

Name: leg_sequencer

Overview:
- Control FSM that runs one inverse-kinematics job per hexapod leg.
- Drives the leg counter's CTR_MODE, SET and TRIGGER inputs and its leg-select input. Consumes the counter's leg-select output.
- Issues per-leg requests to the IK core over a valid/ready handshake, waits for completion, and reports overall done/error status to the AXI register layer.
- Supports single-leg and all-legs (wrap-around) runs, with a timeout and an abort.

Parameters:
- N_LEGS, 6, number of legs.
- N_LEGS_SIZE, $clog2(N_LEGS), leg index width.
- TIMEOUT_CYCLES, 1024, maximum cycles WAIT may last for one leg before error.
- TMR_SIZE, $clog2(TIMEOUT_CYCLES), timeout counter width.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- START  in  1  one-cycle run request from the register layer.
- MODE  in  1  0 = single leg; 1 = all N_LEGS legs, starting at LEG_START.
- LEG_START  in  N_LEGS_SIZE  first leg of the run.
- ABORT  in  1  cancel the run.
- CTR_MODE  out  3  to counter; constant 0 (counter-driven selection).
- CTR_SET  out  1  to counter SET.
- CTR_TRIGGER  out  1  to counter TRIGGER.
- CTR_LEG_IN  out  N_LEGS_SIZE  to counter LEG_IN_SELECT; combinational copy of LEG_START.
- LEG_SELECT  in  N_LEGS_SIZE  counter LEG_OUT_SELECT.
- INVALID_SELECT  in  1  counter range flag for CTR_LEG_IN; combinational.
- IK_VALID  out  1  request to IK core.
- IK_READY  in  1  IK core accepts the request.
- IK_LEG  out  N_LEGS_SIZE  leg index for the request; equals LEG_SELECT.
- IK_DONE  in  1  one-cycle completion pulse from the IK core.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle end-of-run pulse.
- ERROR  out  1  sticky error flag.
- LEG_DONE_MASK  out  N_LEGS  bit i set when leg i has completed in the current run.

Behaviour:
- Reset (async assert, synchronous release):
  - State = IDLE.
  - IK_VALID, CTR_SET, CTR_TRIGGER, DONE, ERROR, BUSY = 0.
  - LEG_DONE_MASK = 0; legs_left = 0; timeout counter = 0.
- Output decoding:
  - CTR_SET = (state == LOAD); CTR_TRIGGER = (state == ADVANCE); IK_VALID = (state == ISSUE). All decoded from the registered state, so they are glitch-free.
  - CTR_SET and CTR_TRIGGER are never high together.
- IDLE:
  - START = 1 and INVALID_SELECT = 1: go to ERR.
  - START = 1 and INVALID_SELECT = 0: go to LOAD. Clear ERROR and LEG_DONE_MASK. Set legs_left = MODE ? N_LEGS : 1.
  - In both START cases, MODE and LEG_START are sampled in that cycle only.
- LOAD (1 cycle): counter loads CTR_LEG_IN at the end of this cycle; next state ISSUE.
- ISSUE:
  - IK_VALID = 1; IK_LEG is stable because the counter does not change in this state.
  - IK_VALID and IK_READY high together: go to WAIT, latch cur_leg = LEG_SELECT, clear the timeout counter.
  - IK_READY low: hold indefinitely (no timeout in ISSUE).
- WAIT:
  - Timeout counter increments every cycle.
  - IK_DONE = 1: set LEG_DONE_MASK[cur_leg] and decrement legs_left.
    - legs_left was 1: go to FINISH.
    - Otherwise: go to ADVANCE.
  - Counter reaches TIMEOUT_CYCLES-1 with IK_DONE = 0: go to ERR.
  - IK_DONE on the same cycle as the timeout limit: IK_DONE wins.
- ADVANCE (1 cycle):
  - Counter increments at the end of this cycle and wraps from N_LEGS-1 to 0.
  - Next state ISSUE.
- FINISH: DONE = 1 for one cycle; go to IDLE.
- ERR: DONE = 1 and ERROR set for one cycle; go to IDLE. ERROR then holds until the next accepted START.
- ABORT:
  - In any non-IDLE state: next state IDLE, no DONE pulse. ERROR and LEG_DONE_MASK keep their values.
  - Has priority over IK_DONE, IK_READY and the timeout.
  - May drop IK_VALID without a handshake; the IK core tolerates this.
  - Ignored in IDLE.
- START outside IDLE: ignored.
- IK_DONE outside WAIT: ignored.
- Latency (START sampled at edge k):
  - LOAD during cycle k+1; IK_VALID first high in cycle k+2.
  - Per additional leg: IK_DONE → ADVANCE → ISSUE, so IK_VALID rises 2 cycles after IK_DONE.
  - Last IK_DONE → DONE pulse in the next cycle.
- Arithmetic: legs_left is N_LEGS_SIZE+1 bits wide so it can hold N_LEGS.

Test Plan:
- Single leg: MODE = 0, LEG_START = 3, START; IK_READY = 1, IK_DONE 5 cycles after handshake → one CTR_SET pulse, IK_LEG = 3, LEG_DONE_MASK = 6'b001000, one DONE pulse, ERROR = 0, no CTR_TRIGGER.
- All legs with wrap: MODE = 1, LEG_START = 4 → IK_LEG sequence 4,5,0,1,2,3; exactly 5 CTR_TRIGGER pulses; LEG_DONE_MASK = 6'b111111; one DONE pulse after the sixth IK_DONE.
- Invalid start: LEG_START = 7, START → no CTR_SET, no IK_VALID; DONE and ERROR asserted in the cycle after START; ERROR stays high until a valid START.
- Timeout: IK_DONE withheld, TIMEOUT_CYCLES = 16 → ERR entered 16 cycles after the handshake; DONE pulse; ERROR = 1; LEG_DONE_MASK bit for that leg = 0.
- Backpressure and abort: IK_READY = 0 for 10 cycles → IK_VALID held with stable IK_LEG. Then ABORT together with IK_READY = 1 → IDLE next cycle, no DONE, BUSY = 0.
- Async reset mid-run (in WAIT): nRST low → all outputs 0 immediately. After release, a new run completes normally, and a stray IK_DONE in IDLE has no effect.

Source files
------------

// File: rtl/leg_sequencer.sv
// rtl/leg_sequencer.sv - per-leg IK job sequencer driving the leg counter and IK core
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   START, MODE          run request; MODE 0 = single leg, 1 = all legs
//   LEG_START            first leg of the run (also forwarded as CTR_LEG_IN)
//   ABORT                cancel a run in progress
//   CTR_MODE/SET/TRIGGER leg counter controls
//   CTR_LEG_IN           counter load value
//   LEG_SELECT           counter output (current leg)
//   INVALID_SELECT       counter range flag for CTR_LEG_IN
//   IK_VALID/READY/LEG   request handshake to the IK core
//   IK_DONE              IK core completion pulse
//   BUSY, DONE, ERROR    run status to the register layer
//   LEG_DONE_MASK        legs completed in the current run
module leg_sequencer #(
  parameter int N_LEGS         = 6,
  parameter int N_LEGS_SIZE    = $clog2(N_LEGS),
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMR_SIZE       = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   START,
  input  logic                   MODE,
  input  logic [N_LEGS_SIZE-1:0] LEG_START,
  input  logic                   ABORT,
  output logic [2:0]             CTR_MODE,
  output logic                   CTR_SET,
  output logic                   CTR_TRIGGER,
  output logic [N_LEGS_SIZE-1:0] CTR_LEG_IN,
  input  logic [N_LEGS_SIZE-1:0] LEG_SELECT,
  input  logic                   INVALID_SELECT,
  output logic                   IK_VALID,
  input  logic                   IK_READY,
  output logic [N_LEGS_SIZE-1:0] IK_LEG,
  input  logic                   IK_DONE,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERROR,
  output logic [N_LEGS-1:0]      LEG_DONE_MASK
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_ADVANCE = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;

  localparam logic [N_LEGS_SIZE:0] ALL_LEGS = (N_LEGS_SIZE+1)'(N_LEGS);
  localparam logic [N_LEGS_SIZE:0] ONE_LEG  = (N_LEGS_SIZE+1)'(1);
  localparam logic [TMR_SIZE-1:0]  TMR_MAX  = TMR_SIZE'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_SIZE-1:0]  TMR_ONE  = TMR_SIZE'(1);

  logic [2:0]             state_q, state_d;
  logic                   error_q, error_d;
  logic [N_LEGS-1:0]      mask_q, mask_d;
  logic [N_LEGS_SIZE:0]   legs_left_q, legs_left_d;
  logic [TMR_SIZE-1:0]    tmr_q, tmr_d;
  logic [N_LEGS_SIZE-1:0] cur_leg_q, cur_leg_d;

  always_comb begin
    state_d     = state_q;
    error_d     = error_q;
    mask_d      = mask_q;
    legs_left_d = legs_left_q;
    tmr_d       = tmr_q;
    cur_leg_d   = cur_leg_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (INVALID_SELECT) begin
            state_d = S_ERR;
          end else begin
            state_d     = S_LOAD;
            error_d     = 1'b0;
            mask_d      = '0;
            legs_left_d = MODE ? ALL_LEGS : ONE_LEG;
          end
        end
      end
      S_LOAD:    state_d = S_ISSUE;
      S_ISSUE: begin
        if (IK_READY) begin
          state_d   = S_WAIT;
          cur_leg_d = LEG_SELECT;
          tmr_d     = '0;
        end
      end
      S_WAIT: begin
        tmr_d = tmr_q + TMR_ONE;
        // Completion is checked before the timeout so a late-but-in-time
        // IK_DONE on the limit cycle still counts as success.
        if (IK_DONE) begin
          mask_d[cur_leg_q] = 1'b1;
          legs_left_d       = legs_left_q - ONE_LEG;
          state_d           = (legs_left_q == ONE_LEG) ? S_FINISH : S_ADVANCE;
        end else if (tmr_q == TMR_MAX) begin
          state_d = S_ERR;
        end
      end
      S_ADVANCE: state_d = S_ISSUE;
      S_FINISH:  state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Abort overrides everything the current state would have done and
    // leaves the run bookkeeping exactly as it was.
    if (ABORT && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      error_d     = error_q;
      mask_d      = mask_q;
      legs_left_d = legs_left_q;
      tmr_d       = tmr_q;
      cur_leg_d   = cur_leg_q;
    end

    // ERROR becomes visible in the same cycle as the ERR state's DONE pulse.
    if (state_d == S_ERR) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      error_q     <= 1'b0;
      mask_q      <= '0;
      legs_left_q <= '0;
      tmr_q       <= '0;
      cur_leg_q   <= '0;
    end else begin
      state_q     <= state_d;
      error_q     <= error_d;
      mask_q      <= mask_d;
      legs_left_q <= legs_left_d;
      tmr_q       <= tmr_d;
      cur_leg_q   <= cur_leg_d;
    end
  end

  assign CTR_MODE      = 3'b000;
  assign CTR_LEG_IN    = LEG_START;
  assign CTR_SET       = (state_q == S_LOAD);
  assign CTR_TRIGGER   = (state_q == S_ADVANCE);
  assign IK_VALID      = (state_q == S_ISSUE);
  assign IK_LEG        = LEG_SELECT;
  assign BUSY          = (state_q != S_IDLE);
  assign DONE          = (state_q == S_FINISH) || (state_q == S_ERR);
  assign ERROR         = error_q;
  assign LEG_DONE_MASK = mask_q;

endmodule

// File: tb/tb_leg_sequencer.sv
// tb/tb_leg_sequencer.sv - scoreboard bench for leg_sequencer
module tb_leg_sequencer;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       START, MODE, ABORT, IK_READY, IK_DONE;
  logic [2:0] LEG_START;
  logic [2:0] CTR_MODE;
  logic       CTR_SET, CTR_TRIGGER, IK_VALID, BUSY, DONE, ERROR;
  logic [2:0] CTR_LEG_IN, LEG_SELECT, IK_LEG;
  logic       INVALID_SELECT;
  logic [5:0] LEG_DONE_MASK;

  logic [2:0] ctr = 3'd0;

  int checks   = 0;
  int failures = 0;

  logic [2:0] leg_q[$];
  logic [6:0] done_q[$];

  int set_cnt   = 0;
  int trig_cnt  = 0;
  int valid_cnt = 0;

  always #5 CLK = ~CLK;

  leg_sequencer #(.N_LEGS(6), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .nRST(nRST), .START(START), .MODE(MODE), .LEG_START(LEG_START),
    .ABORT(ABORT), .CTR_MODE(CTR_MODE), .CTR_SET(CTR_SET), .CTR_TRIGGER(CTR_TRIGGER),
    .CTR_LEG_IN(CTR_LEG_IN), .LEG_SELECT(LEG_SELECT), .INVALID_SELECT(INVALID_SELECT),
    .IK_VALID(IK_VALID), .IK_READY(IK_READY), .IK_LEG(IK_LEG), .IK_DONE(IK_DONE),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .LEG_DONE_MASK(LEG_DONE_MASK)
  );

  // Leg counter model: load on SET, increment with wrap on TRIGGER.
  always @(posedge CLK) begin
    if (CTR_SET) ctr <= CTR_LEG_IN;
    else if (CTR_TRIGGER) ctr <= (ctr == 3'd5) ? 3'd0 : ctr + 3'd1;
  end
  assign LEG_SELECT     = ctr;
  assign INVALID_SELECT = (CTR_LEG_IN >= 3'd6);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_run(input logic mode, input logic [2:0] leg);
    MODE = mode;
    LEG_START = leg;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Waits for the handshake, then raises IK_DONE in the wait_cycles-th WAIT cycle.
  task automatic do_leg(input int wait_cycles);
    int n = 0;
    while (!(IK_VALID && IK_READY) && n < 50) begin
      tick();
      n++;
    end
    chk("handshake_wait", {31'd0, IK_VALID && IK_READY}, 32'd1);
    tick();
    repeat (wait_cycles - 1) tick();
    IK_DONE = 1'b1;
    tick();
    IK_DONE = 1'b0;
  endtask

  initial begin
    int s0, t0, v0;
    nRST = 1'b0; START = 1'b0; MODE = 1'b0; LEG_START = 3'd0;
    ABORT = 1'b0; IK_READY = 1'b1; IK_DONE = 1'b0;

    fork
      forever begin
        @(negedge CLK);
        if (CTR_SET) set_cnt++;
        if (CTR_TRIGGER) trig_cnt++;
        if (IK_VALID) valid_cnt++;
        if (CTR_SET || CTR_TRIGGER)
          chk("set_trig_exclusive", {31'd0, CTR_SET && CTR_TRIGGER}, 32'd0);
        if (IK_VALID && IK_READY && !ABORT) begin
          if (leg_q.size() == 0) chk("unexpected_handshake", {29'd0, IK_LEG}, 32'hFFFF);
          else chk("ik_leg", {29'd0, IK_LEG}, {29'd0, leg_q.pop_front()});
        end
        if (DONE) begin
          if (done_q.size() == 0) chk("unexpected_done", {25'd0, ERROR, LEG_DONE_MASK}, 32'hFFFF);
          else chk("done_err_mask", {25'd0, ERROR, LEG_DONE_MASK}, {25'd0, done_q.pop_front()});
        end
      end
    join_none

    repeat (3) tick();
    chk("reset_outputs", {22'd0, BUSY, DONE, ERROR, IK_VALID, CTR_SET, CTR_TRIGGER, LEG_DONE_MASK}, 32'd0);
    chk("ctr_mode", {29'd0, CTR_MODE}, 32'd0);
    nRST = 1'b1;
    tick();

    // Single leg 3.
    s0 = set_cnt; t0 = trig_cnt;
    leg_q.push_back(3'd3);
    done_q.push_back({1'b0, 6'b001000});
    start_run(1'b0, 3'd3);
    chk("load_cycle_set", {31'd0, CTR_SET}, 32'd1);
    tick();
    chk("issue_latency", {31'd0, IK_VALID}, 32'd1);
    do_leg(5);
    chk("single_done_next", {31'd0, DONE}, 32'd1);
    tick();
    chk("single_set_pulses", set_cnt - s0, 32'd1);
    chk("single_trig_pulses", trig_cnt - t0, 32'd0);
    chk("single_busy_end", {31'd0, BUSY}, 32'd0);

    // All legs with wrap from 4.
    s0 = set_cnt; t0 = trig_cnt;
    leg_q.push_back(3'd4); leg_q.push_back(3'd5); leg_q.push_back(3'd0);
    leg_q.push_back(3'd1); leg_q.push_back(3'd2); leg_q.push_back(3'd3);
    done_q.push_back({1'b0, 6'b111111});
    start_run(1'b1, 3'd4);
    for (int i = 0; i < 6; i++) do_leg(i + 1);
    chk("all_done_next", {31'd0, DONE}, 32'd1);
    tick();
    chk("all_trig_pulses", trig_cnt - t0, 32'd5);
    chk("all_set_pulses", set_cnt - s0, 32'd1);

    // Invalid start leg.
    s0 = set_cnt; v0 = valid_cnt;
    done_q.push_back({1'b1, 6'b111111});
    start_run(1'b0, 3'd7);
    chk("invalid_done", {31'd0, DONE}, 32'd1);
    chk("invalid_error", {31'd0, ERROR}, 32'd1);
    repeat (4) tick();
    chk("invalid_error_sticky", {31'd0, ERROR}, 32'd1);
    chk("invalid_no_set", set_cnt - s0, 32'd0);
    chk("invalid_no_valid", valid_cnt - v0, 32'd0);

    // Timeout on leg 1.
    leg_q.push_back(3'd1);
    done_q.push_back({1'b1, 6'b000000});
    start_run(1'b0, 3'd1);
    chk("start_clears_error", {31'd0, ERROR}, 32'd0);
    begin
      int n = 0;
      while (!(IK_VALID && IK_READY) && n < 50) begin tick(); n++; end
      chk("timeout_hs_wait", {31'd0, IK_VALID && IK_READY}, 32'd1);
    end
    tick();
    repeat (15) tick();
    chk("timeout_not_yet", {31'd0, DONE}, 32'd0);
    tick();
    chk("timeout_done", {31'd0, DONE}, 32'd1);
    chk("timeout_error_mask", {25'd0, ERROR, LEG_DONE_MASK}, {25'd0, 1'b1, 6'b000000});
    tick();

    // Backpressure then abort.
    IK_READY = 1'b0;
    start_run(1'b1, 3'd2);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid_leg", {28'd0, IK_VALID, IK_LEG}, {28'd0, 1'b1, 3'd2});
      tick();
    end
    ABORT = 1'b1; IK_READY = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("abort_idle", {29'd0, BUSY, DONE, IK_VALID}, 32'd0);
    chk("abort_keeps_flags", {25'd0, ERROR, LEG_DONE_MASK}, 32'd0);
    tick();

    // Async reset mid-WAIT.
    leg_q.push_back(3'd5);
    start_run(1'b0, 3'd5);
    begin
      int n = 0;
      while (!(IK_VALID && IK_READY) && n < 50) begin tick(); n++; end
      chk("rst_hs_wait", {31'd0, IK_VALID && IK_READY}, 32'd1);
    end
    tick();
    chk("rst_in_wait", {31'd0, BUSY}, 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("async_rst_outputs", {22'd0, BUSY, DONE, ERROR, IK_VALID, CTR_SET, CTR_TRIGGER, LEG_DONE_MASK}, 32'd0);
    tick();
    nRST = 1'b1;
    IK_DONE = 1'b1;
    tick();
    IK_DONE = 1'b0;
    chk("stray_ik_done", {25'd0, BUSY, LEG_DONE_MASK}, 32'd0);

    leg_q.push_back(3'd0);
    done_q.push_back({1'b0, 6'b000001});
    start_run(1'b0, 3'd0);
    do_leg(3);
    chk("post_rst_done", {31'd0, DONE}, 32'd1);
    repeat (2) tick();

    chk("leg_queue_empty", leg_q.size(), 32'd0);
    chk("done_queue_empty", done_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
